// File: rtl/ipv4_rx_decoder.sv
// Receive-side IPv4 header stripper: validates the header of a 32-bit word stream
// and forwards the UDP payload plus addresses/length to the downstream UDP decoder.
module ipv4_rx_decoder #(
    parameter logic [7:0] UDP_PROTO  = 8'd17,
    parameter bit         CHECK_CSUM = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    input  logic        start_in,
    output logic [31:0] data,
    output logic        valid_out,
    output logic        start,
    output logic        fin,
    output logic [31:0] src_ip,
    output logic [31:0] dest_ip,
    output logic [15:0] len_udp,
    output logic        err,
    output logic [2:0]  err_code
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        OPT     = 3'd2,
        PAYLOAD = 3'd3,
        DROP    = 3'd4
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_VERSION = 3'd1;
    localparam logic [2:0] ERR_LENGTH  = 3'd2;
    localparam logic [2:0] ERR_CSUM    = 3'd3;
    localparam logic [2:0] ERR_PROTO   = 3'd4;
    localparam logic [2:0] ERR_FRAG    = 3'd5;
    localparam logic [2:0] ERR_ABORT   = 3'd6;

    function automatic logic [15:0] fold_sum(input logic [19:0] s);
        logic [19:0] t;
        t = {4'd0, s[15:0]} + {16'd0, s[19:16]};
        t = {4'd0, t[15:0]} + {16'd0, t[19:16]};
        return t[15:0];
    endfunction

    function automatic logic [19:0] add_halves(input logic [19:0] s, input logic [31:0] w);
        return s + {4'd0, w[31:16]} + {4'd0, w[15:0]};
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  version_r, version_s;
    logic [3:0]  ihl_r, ihl_s;
    logic [3:0]  hdr_cnt_r, hdr_cnt_s;
    logic [15:0] total_len_r, total_len_s;
    logic [19:0] sum_r, sum_s, sum_acc_s;
    logic        mf_r, mf_s;
    logic [12:0] offset_r, offset_s;
    logic [7:0]  proto_r, proto_s;
    logic [31:0] src_tmp_r, src_tmp_s;
    logic [31:0] dst_tmp_r, dst_tmp_s;
    logic [14:0] pay_cnt_r, pay_cnt_s;
    logic        first_r, first_s;

    logic [31:0] data_s, src_ip_s, dest_ip_s;
    logic        valid_out_s, start_s, fin_s, err_s;
    logic [15:0] len_udp_s;
    logic [2:0]  err_code_s;

    logic [15:0] hdr_bytes_s, len_calc_s;
    logic [16:0] len_round_s;
    logic [14:0] pay_words_s;
    logic [2:0]  eval_code_s;
    logic [31:0] eval_dest_s;
    logic        do_eval_s;

    // Header verdict, computed against the sum including the word on data_in.
    always_comb begin
        sum_acc_s   = add_halves(sum_r, data_in);
        hdr_bytes_s = {10'd0, ihl_r, 2'b00};
        len_calc_s  = total_len_r - hdr_bytes_s;
        len_round_s = {1'b0, len_calc_s} + 17'd3;
        pay_words_s = len_round_s[16:2];
        eval_dest_s = (state_r == HDR) ? data_in : dst_tmp_r;
        if (version_r != 4'd4) begin
            eval_code_s = ERR_VERSION;
        end else if ((ihl_r < 4'd5) || (total_len_r < hdr_bytes_s)) begin
            eval_code_s = ERR_LENGTH;
        end else if (CHECK_CSUM && (fold_sum(sum_acc_s) != 16'hFFFF)) begin
            eval_code_s = ERR_CSUM;
        end else if (proto_r != UDP_PROTO) begin
            eval_code_s = ERR_PROTO;
        end else if (mf_r || (offset_r != 13'd0)) begin
            eval_code_s = ERR_FRAG;
        end else begin
            eval_code_s = ERR_NONE;
        end
    end

    // Next-state and next-output logic; nothing advances unless valid_in is high.
    always_comb begin
        state_s     = state_r;
        version_s   = version_r;
        ihl_s       = ihl_r;
        hdr_cnt_s   = hdr_cnt_r;
        total_len_s = total_len_r;
        sum_s       = sum_r;
        mf_s        = mf_r;
        offset_s    = offset_r;
        proto_s     = proto_r;
        src_tmp_s   = src_tmp_r;
        dst_tmp_s   = dst_tmp_r;
        pay_cnt_s   = pay_cnt_r;
        first_s     = first_r;
        data_s      = data;
        valid_out_s = 1'b0;
        start_s     = 1'b0;
        fin_s       = 1'b0;
        src_ip_s    = src_ip;
        dest_ip_s   = dest_ip;
        len_udp_s   = len_udp;
        err_s       = 1'b0;
        err_code_s  = ERR_NONE;
        do_eval_s   = 1'b0;

        if (valid_in) begin
            if (start_in) begin
                // A new start always wins; an unfinished packet is reported as aborted.
                if ((state_r == HDR) || (state_r == OPT) ||
                    ((state_r == PAYLOAD) && (pay_cnt_r != 15'd0))) begin
                    err_s      = 1'b1;
                    err_code_s = ERR_ABORT;
                end else begin
                    err_s      = 1'b0;
                    err_code_s = ERR_NONE;
                end
                version_s   = data_in[31:28];
                ihl_s       = data_in[27:24];
                total_len_s = data_in[15:0];
                sum_s       = {4'd0, data_in[31:16]} + {4'd0, data_in[15:0]};
                hdr_cnt_s   = 4'd1;
                state_s     = HDR;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_s = IDLE;
                    end
                    HDR: begin
                        sum_s     = sum_acc_s;
                        hdr_cnt_s = hdr_cnt_r + 4'd1;
                        case (hdr_cnt_r)
                            4'd1: begin
                                mf_s     = data_in[13];
                                offset_s = data_in[12:0];
                            end
                            4'd2: proto_s   = data_in[23:16];
                            4'd3: src_tmp_s = data_in;
                            4'd4: begin
                                dst_tmp_s = data_in;
                                if (ihl_r > 4'd5) begin
                                    state_s = OPT;
                                end else begin
                                    do_eval_s = 1'b1;
                                end
                            end
                            default: state_s = IDLE;
                        endcase
                    end
                    OPT: begin
                        sum_s     = sum_acc_s;
                        hdr_cnt_s = hdr_cnt_r + 4'd1;
                        if (hdr_cnt_r == (ihl_r - 4'd1)) begin
                            do_eval_s = 1'b1;
                        end else begin
                            state_s = OPT;
                        end
                    end
                    PAYLOAD: begin
                        data_s      = data_in;
                        valid_out_s = 1'b1;
                        start_s     = first_r;
                        first_s     = 1'b0;
                        fin_s       = (pay_cnt_r == 15'd1);
                        pay_cnt_s   = pay_cnt_r - 15'd1;
                        if (pay_cnt_r == 15'd1) begin
                            state_s = IDLE;
                        end else begin
                            state_s = PAYLOAD;
                        end
                    end
                    DROP: begin
                        state_s = DROP;
                    end
                    default: begin
                        state_s = IDLE;
                    end
                endcase
            end
        end else begin
            state_s = state_r;
        end

        if (do_eval_s) begin
            if (eval_code_s != ERR_NONE) begin
                err_s      = 1'b1;
                err_code_s = eval_code_s;
                state_s    = DROP;
            end else begin
                src_ip_s  = src_tmp_r;
                dest_ip_s = eval_dest_s;
                len_udp_s = len_calc_s;
                pay_cnt_s = pay_words_s;
                first_s   = 1'b1;
                state_s   = (len_calc_s == 16'd0) ? IDLE : PAYLOAD;
            end
        end else begin
            first_s = first_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Header fields, running sum, payload counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            version_r   <= 4'd0;
            ihl_r       <= 4'd0;
            hdr_cnt_r   <= 4'd0;
            total_len_r <= 16'd0;
            sum_r       <= 20'd0;
            mf_r        <= 1'b0;
            offset_r    <= 13'd0;
            proto_r     <= 8'd0;
            src_tmp_r   <= 32'd0;
            dst_tmp_r   <= 32'd0;
            pay_cnt_r   <= 15'd0;
            first_r     <= 1'b0;
            data        <= 32'd0;
            valid_out   <= 1'b0;
            start       <= 1'b0;
            fin         <= 1'b0;
            src_ip      <= 32'd0;
            dest_ip     <= 32'd0;
            len_udp     <= 16'd0;
            err         <= 1'b0;
            err_code    <= 3'd0;
        end else begin
            version_r   <= version_s;
            ihl_r       <= ihl_s;
            hdr_cnt_r   <= hdr_cnt_s;
            total_len_r <= total_len_s;
            sum_r       <= sum_s;
            mf_r        <= mf_s;
            offset_r    <= offset_s;
            proto_r     <= proto_s;
            src_tmp_r   <= src_tmp_s;
            dst_tmp_r   <= dst_tmp_s;
            pay_cnt_r   <= pay_cnt_s;
            first_r     <= first_s;
            data        <= data_s;
            valid_out   <= valid_out_s;
            start       <= start_s;
            fin         <= fin_s;
            src_ip      <= src_ip_s;
            dest_ip     <= dest_ip_s;
            len_udp     <= len_udp_s;
            err         <= err_s;
            err_code    <= err_code_s;
        end
    end

endmodule

// File: tb/tb_ipv4_rx_decoder.sv
// Bench for ipv4_rx_decoder: directed packets from the reference cases plus randomized
// packets, checked against a packet-level model of the header rules.
module tb_ipv4_rx_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in, start_in;
    logic [31:0] data, src_ip, dest_ip;
    logic        valid_out, start, fin, err;
    logic [15:0] len_udp;
    logic [2:0]  err_code;

    always #5 clk = ~clk;

    ipv4_rx_decoder #(.UDP_PROTO(8'd17), .CHECK_CSUM(1'b1)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .start_in(start_in),
        .data(data), .valid_out(valid_out), .start(start), .fin(fin), .src_ip(src_ip),
        .dest_ip(dest_ip), .len_udp(len_udp), .err(err), .err_code(err_code)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        f;
    } ow_t;

    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;
    int   start_stamp = -1;
    int   err_stamp = -1;
    int   w0_stamp = 0;
    ow_t  obs_q[$];
    ow_t  exp_q[$];
    logic [2:0] obs_err_q[$];
    logic [2:0] exp_err_q[$];

    logic [3:0]  f_ver, f_ihl;
    logic [15:0] f_tl, f_id;
    logic [7:0]  f_ttl, f_proto;
    logic        f_df, f_mf, f_bad;
    logic [12:0] f_off;
    logic [31:0] f_src, f_dst;
    int          n_pay;
    logic [31:0] pay_fixed[$];
    logic [31:0] pkt_q[$];
    int          stall_q[$];

    logic [31:0] exp_src = 32'd0;
    logic [31:0] exp_dst = 32'd0;
    logic [15:0] exp_len = 16'd0;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    // Output monitor: records every payload word and error pulse outside reset.
    always @(negedge clk) begin
        if (reset) begin
            if (valid_out) obs_q.push_back(ow_t'({data, start, fin}));
            if ((start || fin) && !valid_out) obs_q.push_back(ow_t'({32'hDEAD_BEEF, 1'b1, 1'b1}));
            if (start) start_stamp = edge_cnt;
            if (err) begin
                obs_err_q.push_back(err_code);
                err_stamp = edge_cnt;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, req);
        end
    endtask

    task automatic drive(input logic [31:0] w, input logic s, input logic v);
        data_in  = w;
        start_in = s;
        valid_in = v;
        @(posedge clk);
        #1;
    endtask

    function automatic int ones_sum(input int n);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) s = s + int'(pkt_q[i][31:16]) + int'(pkt_q[i][15:0]);
        while (s > 65535) s = (s & 65535) + (s >> 16);
        return s;
    endfunction

    task automatic build_pkt();
        int hn;
        int t;
        logic [15:0] cs;
        pkt_q.delete();
        hn = (f_ihl < 4'd5) ? 5 : int'(f_ihl);
        pkt_q.push_back({f_ver, f_ihl, 8'h00, f_tl});
        pkt_q.push_back({f_id, 1'b0, f_df, f_mf, f_off});
        pkt_q.push_back({f_ttl, f_proto, 16'h0000});
        pkt_q.push_back(f_src);
        pkt_q.push_back(f_dst);
        for (int i = 5; i < hn; i++) pkt_q.push_back($urandom);
        t  = ones_sum(hn);
        cs = ~t[15:0];
        if (f_bad) cs = cs ^ 16'h0100;
        pkt_q[2][15:0] = cs;
        if (pay_fixed.size() > 0) begin
            foreach (pay_fixed[i]) pkt_q.push_back(pay_fixed[i]);
        end else begin
            for (int i = 0; i < n_pay; i++) pkt_q.push_back($urandom);
        end
    endtask

    task automatic send_pkt(input int cut, input int stall_pct);
        for (int i = 0; i < cut; i++) begin
            foreach (stall_q[j]) if (stall_q[j] == i) drive($urandom, 1'($urandom), 1'b0);
            while ((stall_pct > 0) && ($urandom_range(0, 99) < stall_pct))
                drive($urandom, 1'($urandom), 1'b0);
            drive(pkt_q[i], 1'(i == 0), 1'b1);
            if (i == 0) w0_stamp = edge_cnt;
        end
    endtask

    // Packet-level reference: verdict from the header words, then the expected outputs.
    task automatic model_pkt(input int cut, input bit aborted);
        int hn, ihl, tl, code, len, cnt, k;
        ihl = int'(f_ihl);
        tl  = int'(f_tl);
        hn  = (ihl < 5) ? 5 : ihl;
        if (aborted && (cut < hn)) begin
            exp_err_q.push_back(3'd6);
            return;
        end
        if (pkt_q[0][31:28] != 4'd4) code = 1;
        else if ((ihl < 5) || (tl < ihl * 4)) code = 2;
        else if (ones_sum(hn) != 65535) code = 3;
        else if (pkt_q[2][23:16] != 8'd17) code = 4;
        else if (pkt_q[1][13] || (pkt_q[1][12:0] != 13'd0)) code = 5;
        else code = 0;
        if (code != 0) begin
            exp_err_q.push_back(3'(code));
            return;
        end
        len = tl - ihl * 4;
        cnt = (len + 3) / 4;
        exp_src = pkt_q[3];
        exp_dst = pkt_q[4];
        exp_len = 16'(len);
        k = cut - hn;
        for (int j = 0; (j < k) && (j < cnt); j++)
            exp_q.push_back(ow_t'({pkt_q[hn + j], 1'(j == 0), 1'(j == cnt - 1)}));
        if (aborted && (k < cnt)) exp_err_q.push_back(3'd6);
    endtask

    task automatic flush_check(input string tag);
        repeat (3) drive(32'd0, 1'b0, 1'b0);
        chk({tag, "/n_words"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; (i < obs_q.size()) && (i < exp_q.size()); i++)
            chk({tag, "/word"}, 64'(obs_q[i]), 64'(exp_q[i]));
        chk({tag, "/n_err"}, 64'(obs_err_q.size()), 64'(exp_err_q.size()));
        for (int i = 0; (i < obs_err_q.size()) && (i < exp_err_q.size()); i++)
            chk({tag, "/err_code"}, 64'(obs_err_q[i]), 64'(exp_err_q[i]));
        chk({tag, "/src_ip"}, 64'(src_ip), 64'(exp_src));
        chk({tag, "/dest_ip"}, 64'(dest_ip), 64'(exp_dst));
        chk({tag, "/len_udp"}, 64'(len_udp), 64'(exp_len));
        obs_q.delete();
        exp_q.delete();
        obs_err_q.delete();
        exp_err_q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/valid_out"}, 64'(valid_out), 64'd0);
        chk({tag, "/start"}, 64'(start), 64'd0);
        chk({tag, "/fin"}, 64'(fin), 64'd0);
        chk({tag, "/err"}, 64'(err), 64'd0);
        chk({tag, "/err_code"}, 64'(err_code), 64'd0);
        chk({tag, "/data"}, 64'(data), 64'd0);
        chk({tag, "/src_ip"}, 64'(src_ip), 64'd0);
        chk({tag, "/dest_ip"}, 64'(dest_ip), 64'd0);
        chk({tag, "/len_udp"}, 64'(len_udp), 64'd0);
    endtask

    task automatic set_ref_pkt();
        f_ver = 4'd4; f_ihl = 4'd5; f_tl = 16'h0027; f_id = 16'h0000;
        f_df = 1'b1; f_mf = 1'b0; f_off = 13'd0; f_ttl = 8'h40; f_proto = 8'h11;
        f_src = 32'h9801_331b; f_dst = 32'h980e_5e4b; f_bad = 1'b0; n_pay = 5;
        pay_fixed = '{32'ha08f_2694, 32'h0013_2560, 32'h4865_6c6c, 32'h6f20_576f, 32'h726c_6400};
    endtask

    initial begin
        int kind, len, cut;
        bit aborted;
        reset = 1'b0;
        data_in = 32'd0; valid_in = 1'b0; start_in = 1'b0;
        repeat (3) drive(32'd0, 1'b0, 1'b0);
        check_zero("reset");
        reset = 1'b1;
        drive(32'd0, 1'b0, 1'b0);

        set_ref_pkt(); build_pkt(); start_stamp = -1;
        send_pkt(pkt_q.size(), 0); model_pkt(pkt_q.size(), 1'b0);
        flush_check("ref_good");
        chk("ref_good/src_const", 64'(src_ip), 64'h9801_331b);
        chk("ref_good/dst_const", 64'(dest_ip), 64'h980e_5e4b);
        chk("ref_good/len_const", 64'(len_udp), 64'h0013);
        chk("ref_good/start_latency", 64'(start_stamp - w0_stamp), 64'd5);

        set_ref_pkt(); f_bad = 1'b1; build_pkt(); err_stamp = -1;
        send_pkt(pkt_q.size(), 0); model_pkt(pkt_q.size(), 1'b0);
        flush_check("bad_csum");
        chk("bad_csum/err_latency", 64'(err_stamp - w0_stamp), 64'd4);

        set_ref_pkt(); f_proto = 8'h06; build_pkt();
        send_pkt(pkt_q.size(), 0); model_pkt(pkt_q.size(), 1'b0);
        set_ref_pkt(); f_src = 32'h0a00_0001; build_pkt();
        send_pkt(pkt_q.size(), 0); model_pkt(pkt_q.size(), 1'b0);
        flush_check("proto_then_good");

        set_ref_pkt(); f_ihl = 4'd6; f_tl = 16'h002b; build_pkt(); start_stamp = -1;
        send_pkt(pkt_q.size(), 0); model_pkt(pkt_q.size(), 1'b0);
        flush_check("ihl6");
        chk("ihl6/start_latency", 64'(start_stamp - w0_stamp), 64'd6);

        set_ref_pkt(); build_pkt(); stall_q = '{2, 2, 7};
        send_pkt(pkt_q.size(), 0); model_pkt(pkt_q.size(), 1'b0);
        stall_q.delete();
        flush_check("stalls");

        set_ref_pkt(); f_dst = 32'hc0a8_0102; build_pkt();
        send_pkt(7, 0); model_pkt(7, 1'b0);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        check_zero("mid_reset");
        exp_src = 32'd0; exp_dst = 32'd0; exp_len = 16'd0;
        repeat (2) drive(32'd0, 1'b0, 1'b0);
        reset = 1'b1;
        flush_check("mid_reset_tail");
        set_ref_pkt(); build_pkt();
        send_pkt(pkt_q.size(), 0); model_pkt(pkt_q.size(), 1'b0);
        flush_check("after_reset");

        set_ref_pkt(); build_pkt();
        send_pkt(7, 0); model_pkt(7, 1'b1);
        set_ref_pkt(); f_src = 32'h0102_0304; build_pkt();
        send_pkt(pkt_q.size(), 0); model_pkt(pkt_q.size(), 1'b0);
        flush_check("abort");

        pay_fixed.delete();
        for (int p = 0; p < 200; p++) begin
            kind  = $urandom_range(0, 11);
            f_ver = 4'd4; f_ihl = 4'($urandom_range(5, 8));
            len   = $urandom_range(0, 40);
            f_tl  = 16'(int'(f_ihl) * 4 + len);
            f_id = 16'($urandom); f_ttl = 8'($urandom); f_df = 1'($urandom);
            f_mf = 1'b0; f_off = 13'd0; f_proto = 8'd17; f_bad = 1'b0;
            f_src = $urandom; f_dst = $urandom;
            n_pay = (len + 3) / 4 + $urandom_range(0, 2);
            case (kind)
                1: begin
                    f_ver = 4'($urandom_range(0, 15));
                    if (f_ver == 4'd4) f_ver = 4'd6;
                end
                2: f_ihl = 4'($urandom_range(0, 4));
                3: begin
                    f_tl  = 16'($urandom_range(0, int'(f_ihl) * 4 - 1));
                    n_pay = $urandom_range(0, 3);
                end
                4: f_bad = 1'b1;
                5: begin
                    f_proto = 8'($urandom);
                    if (f_proto == 8'd17) f_proto = 8'd6;
                end
                6: begin
                    if ($urandom_range(0, 1) == 0) f_mf = 1'b1;
                    else f_off = 13'($urandom_range(1, 8191));
                end
                default: f_ver = 4'd4;
            endcase
            build_pkt();
            aborted = (p != 199) && (pkt_q.size() > 1) && ($urandom_range(0, 99) < 15);
            cut = aborted ? $urandom_range(1, pkt_q.size() - 1) : pkt_q.size();
            send_pkt(cut, 20);
            model_pkt(cut, aborted);
            if (!aborted) flush_check("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
